// File: rtl/cache_pkg.sv
// Shared constants and state encoding for the cache miss fill controller.
package cache_pkg;

  localparam int WORDS_PER_BLOCK = 8;
  localparam int OFFSET_W        = $clog2(WORDS_PER_BLOCK);
  localparam int BLOCK_BYTES     = 2 * WORDS_PER_BLOCK;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;

endpackage

// File: rtl/fill_counter.sv
// Up-counter with synchronous clear, enable and terminal-count flag.
module fill_counter #(
  parameter int W  = 4,
  parameter int TC = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;
  assign tc    = (cnt_q == W'(TC));

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: fetches one block from pipelined memory and streams it into the cache.
// Optional build macro CACHE_FILL_CRITICAL_WORD_FIRST_EN fetches the missed word first and wraps.
module cache_fill_fsm #(
  parameter int MEM_LATENCY     = 4,
  parameter int WORDS_PER_BLOCK = cache_pkg::WORDS_PER_BLOCK,
  parameter int ADDR_W          = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               miss_detected,
  input  logic [ADDR_W-1:0]                  miss_address,
  input  logic                               memory_data_valid,
  input  logic [15:0]                        memory_data_in,
  output logic                               fsm_busy,
  output logic                               mem_en,
  output logic [ADDR_W-1:0]                  memory_address,
  output logic                               write_data_array,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word,
  output logic [15:0]                        fill_data,
  output logic                               write_tag_array
);

  import cache_pkg::*;

  localparam int OFF_W     = $clog2(WORDS_PER_BLOCK);
  localparam int CNT_W     = OFF_W + 1;
  localparam int BLK_BYTES = 2 * WORDS_PER_BLOCK;

  // Completion is counted on returned valids, so the latency only has to be sane.
  if (MEM_LATENCY < 1 || (WORDS_PER_BLOCK & (WORDS_PER_BLOCK - 1)) != 0) begin : g_param_check
    $error("cache_fill_fsm: MEM_LATENCY must be >= 1 and WORDS_PER_BLOCK a power of 2");
  end

  fill_state_t       state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [OFF_W-1:0]  start_off;
  logic              cnt_clr;

  logic              filling;
  logic              issue_en, issue_tc;
  logic              rx_en, rx_last;
  logic [CNT_W-1:0]  issue_cnt, rx_cnt;
  logic [OFF_W-1:0]  issue_word, rx_word;

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
  logic [OFF_W-1:0]  start_q, start_d;
  assign start_off = start_q;
`else
  assign start_off = '0;
`endif

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    cnt_clr = 1'b0;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    start_d = start_q;
`endif
    case (state_q)
      IDLE: begin
        if (miss_detected) begin
          base_d  = miss_address & ~ADDR_W'(BLK_BYTES - 1);
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
          start_d = miss_address[OFF_W:1];
`endif
          cnt_clr = 1'b1;
          state_d = FILL;
        end
      end
      FILL: begin
        if (rx_en && rx_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
      start_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
      start_q <= start_d;
`endif
    end
  end

  assign filling  = (state_q == FILL);
  assign issue_en = filling && !issue_tc;
  assign rx_en    = filling && memory_data_valid;

  fill_counter #(.W(CNT_W), .TC(WORDS_PER_BLOCK)) u_issue_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (issue_en),
    .count (issue_cnt),
    .tc    (issue_tc)
  );

  // Terminal count here marks the last word, so the tag write lands with it.
  fill_counter #(.W(CNT_W), .TC(WORDS_PER_BLOCK - 1)) u_rx_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (rx_en),
    .count (rx_cnt),
    .tc    (rx_last)
  );

  assign issue_word = OFF_W'((int'(start_off) + int'(issue_cnt)) % WORDS_PER_BLOCK);
  assign rx_word    = OFF_W'((int'(start_off) + int'(rx_cnt)) % WORDS_PER_BLOCK);

  assign fsm_busy         = filling;
  assign mem_en           = issue_en;
  assign memory_address   = issue_en ? (base_q + (ADDR_W'(issue_word) << 1)) : '0;
  assign write_data_array = rx_en;
  assign fill_word        = rx_en ? rx_word : '0;
  assign fill_data        = memory_data_in;
  assign write_tag_array  = rx_en && rx_last;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Table-driven bench for cache_fill_fsm: one row per clock cycle with inputs and expected outputs.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        memory_data_valid;
  logic [15:0] memory_data_in;
  logic        fsm_busy;
  logic        mem_en;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [2:0]  fill_word;
  logic [15:0] fill_data;
  logic        write_tag_array;

  always #5 clk = ~clk;

  cache_fill_fsm dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .memory_data_in    (memory_data_in),
    .fsm_busy          (fsm_busy),
    .mem_en            (mem_en),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .fill_word         (fill_word),
    .fill_data         (fill_data),
    .write_tag_array   (write_tag_array)
  );

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  typedef struct {
    logic        rst;
    logic        miss;
    logic [15:0] addr;
    logic        valid;
    logic [15:0] data;
    logic        busy;
    logic        men;
    logic [15:0] maddr;
    logic        wda;
    logic [2:0]  fw;
    logic        wta;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t zero_row();
    vec_t v;
    v.rst = 1'b0; v.miss = 1'b0; v.addr = 16'h0; v.valid = 1'b0; v.data = 16'h0;
    v.busy = 1'b0; v.men = 1'b0; v.maddr = 16'h0; v.wda = 1'b0; v.fw = 3'd0; v.wta = 1'b0;
    return v;
  endfunction

  // Rows 0..12 of one fill: miss in row 0, requests in rows 1..8, returns in rows 5..12.
  function automatic void add_fill(logic [15:0] addr, logic [15:0] dbase, int rst_at, int stray_at);
    logic [15:0] base;
    int          start;
    base  = addr & 16'hFFF0;
    start = CWF ? int'(addr[3:1]) : 0;
    for (int r = 0; r < 13; r++) begin
      vec_t v;
      bit   alive;
      v     = zero_row();
      alive = (rst_at < 0) || (r <= rst_at);
      v.rst   = (r == rst_at);
      v.miss  = (r == 0) || (r == stray_at);
      v.addr  = (r == 0) ? addr : ((r == stray_at) ? 16'h5000 : 16'h0);
      v.valid = (r >= 5);
      v.data  = (r >= 5) ? dbase + 16'(r - 5) : 16'h0;
      v.busy  = alive && (r >= 1);
      v.men   = alive && (r >= 1) && (r <= 8);
      v.maddr = v.men ? base + 16'(2 * ((start + r - 1) % 8)) : 16'h0;
      v.wda   = alive && (r >= 5);
      v.fw    = v.wda ? 3'((start + r - 5) % 8) : 3'd0;
      v.wta   = v.wda && (r == 12);
      vecs.push_back(v);
    end
  endfunction

  function automatic void add_idle(logic valid, logic [15:0] data);
    vec_t v;
    v       = zero_row();
    v.valid = valid;
    v.data  = data;
    vecs.push_back(v);
  endfunction

  task automatic check(string name, int row, logic [15:0] act, logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  initial begin
    vec_t rst_row;
    rst = 1'b1; miss_detected = 1'b0; miss_address = 16'h0;
    memory_data_valid = 1'b0; memory_data_in = 16'h0;
    repeat (3) @(posedge clk);

    rst_row     = zero_row();
    rst_row.rst = 1'b1;
    vecs.push_back(rst_row);
    add_fill(16'h1234, 16'hA000, -1, 6);   // stray miss mid-fill ignored
    add_fill(16'h5000, 16'hB000, -1, -1);  // accepted in first idle cycle after fill
    add_idle(1'b1, 16'hDEAD);              // returns while idle are dropped
    add_idle(1'b1, 16'hBEEF);
    add_fill(16'hFFF6, 16'hC000, -1, -1);  // top-of-address-space block
    add_fill(16'h1234, 16'hD000, 7, -1);   // reset mid-fill
    add_fill(16'h123A, 16'hE000, -1, -1);
    add_idle(1'b0, 16'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      rst               = vecs[i].rst;
      miss_detected     = vecs[i].miss;
      miss_address      = vecs[i].addr;
      memory_data_valid = vecs[i].valid;
      memory_data_in    = vecs[i].data;
      @(negedge clk);
      check("fsm_busy", i, 16'(fsm_busy), 16'(vecs[i].busy));
      check("mem_en", i, 16'(mem_en), 16'(vecs[i].men));
      check("memory_address", i, memory_address, vecs[i].maddr);
      check("write_data_array", i, 16'(write_data_array), 16'(vecs[i].wda));
      check("fill_word", i, 16'(fill_word), 16'(vecs[i].fw));
      check("write_tag_array", i, 16'(write_tag_array), 16'(vecs[i].wta));
      if (vecs[i].wda) begin
        check("fill_data", i, fill_data, vecs[i].data);
      end
      $display("row %0d: rst=%b miss=%b addr=%h valid=%b busy=%b men=%b maddr=%h wda=%b fw=%0d wta=%b",
               i, rst, miss_detected, miss_address, memory_data_valid, fsm_busy, mem_en,
               memory_address, write_data_array, fill_word, write_tag_array);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
